// File: rtl/gray2bin_tracker.sv
// gray2bin_tracker: registered Gray-to-binary decoder with valid/ready
// handshake on both sides, one-deep output register, 1-cycle latency.
// Optional step tracking (dir, step_err, saturating err_count) is built
// only when GRAY_STEP_CHECK_EN is defined; otherwise those outputs are 0.
module gray2bin_tracker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] binary,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dir,
  output logic             step_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             clear
);

  // binary[i] is the XOR of gray[WIDTH-1:i]
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] binary_q, binary_d;
  logic             accept;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign binary    = binary_q;

  // Output word register: load on accept, drop after transfer, else hold
  always_comb begin
    out_valid_d = out_valid_q;
    binary_d    = binary_q;
    if (accept) begin
      out_valid_d = 1'b1;
      binary_d    = gray_to_bin(gray);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output word state flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      binary_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      binary_q    <= binary_d;
    end
  end

`ifdef GRAY_STEP_CHECK_EN

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_ERR   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic             dir_q, dir_d;
  logic             step_err_q, step_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0] step_diff;
  logic             diff_zero;
  logic             diff_multi;
  logic             step_up;

  // More than one bit set <=> clearing the lowest set bit leaves a nonzero word
  assign step_diff  = gray ^ prev_gray_q;
  assign diff_zero  = (step_diff == '0);
  assign diff_multi = |(step_diff & (step_diff - WIDTH'(1)));
  assign step_up    = (gray_to_bin(gray) == (gray_to_bin(prev_gray_q) + WIDTH'(1)));

  assign dir       = dir_q;
  assign step_err  = step_err_q;
  assign err_count = err_count_q;

  // Step-tracking FSM: next state, reference word, dir/step_err and error count.
  // An accept coinciding with clear is handled as the first word after idle,
  // so it leaves the FSM tracking with that word as the new reference.
  always_comb begin
    state_d     = state_q;
    prev_gray_d = prev_gray_q;
    dir_d       = dir_q;
    step_err_d  = step_err_q;
    err_count_d = err_count_q;
    if (accept) begin
      prev_gray_d = gray;
      if (clear || (state_q == S_IDLE)) begin
        step_err_d = 1'b0;
        dir_d      = 1'b0;
        state_d    = S_TRACK;
      end else if (diff_multi) begin
        step_err_d = 1'b1;
        state_d    = S_ERR;
        if (err_count_q != '1) begin
          err_count_d = err_count_q + CNT_W'(1);
        end
      end else begin
        step_err_d = 1'b0;
        state_d    = S_TRACK;
        if (!diff_zero) begin
          dir_d = step_up;
        end
      end
    end else if (clear) begin
      state_d = S_IDLE;
    end
    if (clear) begin
      err_count_d = '0;
    end
  end

  // Step-tracking state flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      prev_gray_q <= '0;
      dir_q       <= 1'b0;
      step_err_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_gray_q <= prev_gray_d;
      dir_q       <= dir_d;
      step_err_q  <= step_err_d;
      err_count_q <= err_count_d;
    end
  end

`else

  logic unused_clear;

  assign unused_clear = clear;
  assign dir          = 1'b0;
  assign step_err     = 1'b0;
  assign err_count    = '0;

`endif

endmodule

// File: tb/tb_gray2bin_tracker.sv
// Self-checking bench for gray2bin_tracker (WIDTH=4, CNT_W=8).
module tb_gray2bin_tracker;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;
`ifdef GRAY_STEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic [WIDTH-1:0] gray      = '0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic             clear     = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] binary;
  logic             out_valid;
  logic             dir;
  logic             step_err;
  logic [CNT_W-1:0] err_count;

  gray2bin_tracker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray      (gray),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .binary    (binary),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dir       (dir),
    .step_err  (step_err),
    .err_count (err_count),
    .clear     (clear)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0] bin;
    logic       dir;
    logic       err;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  exp_t        m_got;
  logic [3:0]  m_prev = '0;
  logic        m_dir = 1'b0;
  logic        m_track = 1'b0;
  int unsigned m_cnt = 0;
  bit          m_expect_valid = 1'b0;
  int          m_d;

  // Reference decode: walk down from the MSB, each bit = bit above ^ gray bit
  function automatic logic [3:0] ref_decode(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, between active edges
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_prev = '0; m_dir = 1'b0; m_track = 1'b0; m_cnt = 0; m_expect_valid = 1'b0;
    end else begin
      if (m_expect_valid) begin
        vectors++;
        if (out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL latency: out_valid=%b expected 1 one cycle after accept", out_valid);
        end
      end
      vectors++;
      if (err_count !== CNT_W'(m_cnt)) begin
        miscompares++;
        $display("FAIL err_count: got %0d expected %0d", err_count, m_cnt);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: binary=%0d emitted with empty scoreboard (expected none)", binary);
        end else begin
          m_e   = sb.pop_front();
          m_got = '{bin: binary, dir: dir, err: step_err};
          if (m_got !== m_e) begin
            miscompares++;
            $display("FAIL word: got bin=%0d dir=%b err=%b expected bin=%0d dir=%b err=%b",
                     binary, dir, step_err, m_e.bin, m_e.dir, m_e.err);
          end
        end
      end
      m_expect_valid = 1'b0;
      if (in_valid && in_ready) begin
        m_e.bin = ref_decode(gray);
        m_e.dir = 1'b0;
        m_e.err = 1'b0;
        if (CHK) begin
          if (clear || !m_track) begin
            m_track = 1'b1;
          end else begin
            m_d = $countones(gray ^ m_prev);
            if (m_d >= 2) begin
              m_e.err = 1'b1;
              m_e.dir = m_dir;
              if (m_cnt < 255) m_cnt++;
            end else if (m_d == 1) begin
              m_e.dir = (m_e.bin == 4'(ref_decode(m_prev) + 4'd1));
            end else begin
              m_e.dir = m_dir;
            end
          end
          m_prev = gray;
          m_dir  = m_e.dir;
        end
        sb.push_back(m_e);
        m_expect_valid = 1'b1;
      end else if (clear) begin
        m_track = 1'b0;
      end
      if (clear) m_cnt = 0;
    end
  end

  // Present one word and hold it until accepted (bounded); returns at edge+1
  task automatic drive_word(input logic [3:0] g);
    bit done = 1'b0;
    gray = g;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL accept_timeout: gray=%b accepted=0 expected 1 within 50 cycles", g);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0; gray = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || binary !== 4'd0 || dir !== 1'b0 || step_err !== 1'b0 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_state: ov=%b bin=%0d dir=%b err=%b cnt=%0d expected all 0",
               out_valid, binary, dir, step_err, err_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    drive_word(4'b0000);
    vectors++;
    if (binary !== 4'd0 || dir !== 1'b0 || step_err !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_w0: bin=%0d dir=%b err=%b expected 0 0 0", binary, dir, step_err);
    end
    drive_word(4'b0001);
    vectors++;
    if (binary !== 4'd1 || dir !== CHK) begin
      miscompares++;
      $display("FAIL stream_w1: bin=%0d dir=%b expected 1 %b", binary, dir, CHK);
    end
    drive_word(4'b0011);
    vectors++;
    if (binary !== 4'd2 || dir !== CHK) begin
      miscompares++;
      $display("FAIL stream_w2: bin=%0d dir=%b expected 2 %b", binary, dir, CHK);
    end
    drive_word(4'b0010);
    vectors++;
    if (binary !== 4'd3 || dir !== CHK || step_err !== 1'b0 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL stream_w3: bin=%0d dir=%b err=%b cnt=%0d expected 3 %b 0 0",
               binary, dir, step_err, err_count, CHK);
    end
  endtask

  task automatic test_dir_err();
    drive_word(4'b0011);
    vectors++;
    if (binary !== 4'd2 || dir !== 1'b0 || step_err !== 1'b0) begin
      miscompares++;
      $display("FAIL down_step: bin=%0d dir=%b err=%b expected 2 0 0", binary, dir, step_err);
    end
    drive_word(4'b1000);
    vectors++;
    if (binary !== 4'd15 || step_err !== CHK || err_count !== (CHK ? 8'd1 : 8'd0)) begin
      miscompares++;
      $display("FAIL jump: bin=%0d err=%b cnt=%0d expected 15 %b %0d",
               binary, step_err, err_count, CHK, CHK ? 1 : 0);
    end
  endtask

  task automatic test_wrap();
    drive_word(4'b1000);
    vectors++;
    if (binary !== 4'd15 || step_err !== 1'b0 || dir !== 1'b0) begin
      miscompares++;
      $display("FAIL repeat: bin=%0d err=%b dir=%b expected 15 0 0", binary, step_err, dir);
    end
    drive_word(4'b0000);
    vectors++;
    if (binary !== 4'd0 || dir !== CHK || step_err !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap: bin=%0d dir=%b err=%b expected 0 %b 0", binary, dir, step_err, CHK);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] snap;
    bit done = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_word(4'b0001);
    snap = {binary, dir, step_err};
    gray = 4'b0011; in_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {binary, dir, step_err} !== snap) begin
        miscompares++;
        $display("FAIL hold: in_ready=%b ov=%b out=%b expected 0 1 %b", in_ready, out_valid,
                 {binary, dir, step_err}, snap);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++;
    if (!done || binary !== 4'd2) begin
      miscompares++;
      $display("FAIL release: accepted=%b bin=%0d expected 1 2", done, binary);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL no_dup: ov=%b pending=%0d expected 0 0", out_valid, sb.size());
    end
  endtask

  task automatic test_saturate_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) drive_word((i % 2 == 0) ? 4'b0000 : 4'b0011);
    vectors++;
    if (err_count !== (CHK ? 8'd255 : 8'd0)) begin
      miscompares++;
      $display("FAIL saturate: cnt=%0d expected %0d", err_count, CHK ? 255 : 0);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    vectors++;
    if (err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL clear: cnt=%0d expected 0", err_count);
    end
    drive_word(4'b0111);
    vectors++;
    if (binary !== 4'd5 || step_err !== 1'b0 || dir !== 1'b0) begin
      miscompares++;
      $display("FAIL after_clear: bin=%0d err=%b dir=%b expected 5 0 0", binary, step_err, dir);
    end
  endtask

  task automatic test_clear_with_accept();
    out_ready = 1'b1;
    clear = 1'b1;
    drive_word(4'b1100);
    clear = 1'b0;
    vectors++;
    if (binary !== 4'd8 || step_err !== 1'b0 || dir !== 1'b0 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL clear_accept: bin=%0d err=%b dir=%b cnt=%0d expected 8 0 0 0",
               binary, step_err, dir, err_count);
    end
    drive_word(4'b1101);
    vectors++;
    if (binary !== 4'd9 || dir !== CHK || step_err !== 1'b0) begin
      miscompares++;
      $display("FAIL track_after_clear: bin=%0d dir=%b err=%b expected 9 %b 0", binary, dir, step_err, CHK);
    end
  endtask

  task automatic test_random();
    logic [3:0] one = 4'b0001;
    int r;
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 9);
      if (r < 6) gray = gray ^ (one << $urandom_range(0, 3));
      else if (r < 8) gray = gray;
      else gray = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL random_drain: pending=%0d expected 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    clear = 1'b1;
    drive_word(4'b0000);
    clear = 1'b0;
    drive_word(4'b0110);
    out_ready = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || binary !== 4'd4 || err_count !== (CHK ? 8'd1 : 8'd0)) begin
      miscompares++;
      $display("FAIL pre_reset: ov=%b bin=%0d cnt=%0d expected 1 4 %0d", out_valid, binary, err_count, CHK ? 1 : 0);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || binary !== 4'd0 || err_count !== 8'd0 || dir !== 1'b0 || step_err !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: ov=%b bin=%0d cnt=%0d dir=%b err=%b expected all 0",
               out_valid, binary, err_count, dir, step_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: in_ready=%b ov=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_dir_err();
    test_wrap();
    test_backpressure();
    test_saturate_clear();
    test_clear_with_accept();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
